// File: rtl/alu_share_ctrl_if.sv
// Requester, ALU and response bundle for alu_share_ctrl.
// slave = controller side, master = requesters/ALU/consumer side.
interface alu_share_ctrl_if #(
  parameter int DATA_SIZE = 32,
  parameter int OP_SIZE   = 5
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [2*OP_SIZE-1:0]   req_op;
  logic [2*DATA_SIZE-1:0] req_src1;
  logic [2*DATA_SIZE-1:0] req_src2;
  logic [OP_SIZE-1:0]     alu_op;
  logic [DATA_SIZE-1:0]   alu_src1;
  logic [DATA_SIZE-1:0]   alu_src2;
  logic [DATA_SIZE-1:0]   alu_result;
  logic                   alu_ovf;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_id;
  logic [DATA_SIZE-1:0]   resp_data;
  logic                   resp_ovf;
  logic                   resp_err;
  logic                   busy;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2,
    input  alu_result, alu_ovf, resp_ready,
    output req_ready, alu_op, alu_src1, alu_src2,
    output resp_valid, resp_id, resp_data,
    output resp_ovf, resp_err, busy
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2,
    output alu_result, alu_ovf, resp_ready,
    input  req_ready, alu_op, alu_src1, alu_src2,
    input  resp_valid, resp_id, resp_data,
    input  resp_ovf, resp_err, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: round-robin
// grant, operand latch, fixed execute window, held response.
// Ports: clk, rst (async, active-high), bus (alu_share_ctrl_if.slave).
module alu_share_ctrl #(
  parameter int                 DATA_SIZE  = 32,
  parameter int                 OP_SIZE    = 5,
  parameter int                 MUL_CYCLES = 2,
  parameter logic [OP_SIZE-1:0] MAX_OP     = 5'b10011
) (
  input logic            clk,
  input logic            rst,
  alu_share_ctrl_if.slave bus
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nx;

  logic                 last_grant;
  logic [CW-1:0]        cnt;
  logic                 win;
  logic [1:0]           grant;
  logic                 fire;
  logic [OP_SIZE-1:0]   op_w;
  logic [DATA_SIZE-1:0] src1_w;
  logic [DATA_SIZE-1:0] src2_w;
  logic                 err_w;
  logic                 addsub;

  logic [OP_SIZE-1:0]   alu_op_q;
  logic [DATA_SIZE-1:0] alu_src1_q;
  logic [DATA_SIZE-1:0] alu_src2_q;
  logic                 resp_valid_q;
  logic                 resp_id_q;
  logic [DATA_SIZE-1:0] resp_data_q;
  logic                 resp_ovf_q;
  logic                 resp_err_q;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    win   = 1'b0;
    grant = 2'b00;
    if (&bus.req_valid) win = ~last_grant;
    else                win = bus.req_valid[1];
    if (state == IDLE && !rst && |bus.req_valid)
      grant = win ? 2'b10 : 2'b01;
  end

  assign fire   = |grant;
  assign op_w   = bus.req_op[(win ? OP_SIZE : 0) +: OP_SIZE];
  assign src1_w = bus.req_src1[(win ? DATA_SIZE : 0) +: DATA_SIZE];
  assign src2_w = bus.req_src2[(win ? DATA_SIZE : 0) +: DATA_SIZE];
  assign err_w  = alu_op_q > MAX_OP;
  assign addsub = alu_op_q[OP_SIZE-1:1] == '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (fire) state_nx = EXEC;
      EXEC:    if (cnt == '0) state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= 1'b1;
      cnt          <= '0;
      alu_op_q     <= '0;
      alu_src1_q   <= '0;
      alu_src2_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            alu_op_q   <= op_w;
            alu_src1_q <= src1_w;
            alu_src2_q <= src2_w;
            resp_id_q  <= win;
            last_grant <= win;
            cnt        <= op_w[OP_SIZE-1] ? MUL_LOAD : '0;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            resp_data_q  <= err_w ? '0 : bus.alu_result;
            resp_ovf_q   <= addsub & bus.alu_ovf;
            resp_err_q   <= err_w;
            resp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) resp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_src1   = alu_src1_q;
  assign bus.alu_src2   = alu_src2_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_ovf   = resp_ovf_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = state != IDLE;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: directed scenarios plus a random run
// against a transaction-level model; includes a behavioural ALU.
module tb_alu_share_ctrl;
  localparam int DW = 32;
  localparam int OW = 5;
  localparam int MC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl_if #(.DATA_SIZE(DW), .OP_SIZE(OW)) bus ();

  alu_share_ctrl #(
    .DATA_SIZE(DW), .OP_SIZE(OW), .MUL_CYCLES(MC), .MAX_OP(5'b10011)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  function automatic logic [32:0] ref_alu(
    input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic o;
    p = '0;
    r = '0;
    o = 1'b0;
    case (op)
      5'd0: begin
        r = a + b;
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd1: begin
        r = a - b;
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd16: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0];
        o = ^r;
      end
      5'd17: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r = p[63:32];
        o = ^r;
      end
      5'd18: begin
        p = {{32{a[31]}}, a} * {32'b0, b};
        r = p[63:32];
        o = ^r;
      end
      5'd19: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[63:32];
        o = ^r;
      end
      default: begin
        r = a ^ (b << op[3:0]) ^ {27'b0, op};
        o = ^r;
      end
    endcase
    return {o, r};
  endfunction

  // Expected {err, ovf, data} for one request.
  function automatic logic [33:0] exp_resp(
    input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r = ref_alu(op, a, b);
    if (op > 5'b10011) return {2'b10, 32'b0};
    return {1'b0, (op < 5'd2) ? r[32] : 1'b0, r[31:0]};
  endfunction

  function automatic int lat(input logic [4:0] op);
    return op[4] ? MC + 1 : 2;
  endfunction

  assign {bus.alu_ovf, bus.alu_result} =
    ref_alu(bus.alu_op, bus.alu_src1, bus.alu_src2);

  task automatic set_req(input int i, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_op[i*OW +: OW]   = op;
    bus.req_src1[i*DW +: DW] = a;
    bus.req_src2[i*DW +: DW] = b;
  endtask

  task automatic wait_resp(output int n);
    n = 1;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.resp_ready = 1'b0;
    set_req(0, 5'd0, 32'd1, 32'd2);
    set_req(1, 5'd0, 32'd3, 32'd4);
    @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b want 00", bus.req_ready);
    end
    checks++;
    if ({bus.alu_op, bus.alu_src1, bus.alu_src2} !== '0) begin
      errors++;
      $display("FAIL reset_alu: got %h %h %h want 0",
               bus.alu_op, bus.alu_src1, bus.alu_src2);
    end
    checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_ovf,
         bus.resp_err, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_resp: got v%b id%b d%h o%b e%b busy%b want 0",
               bus.resp_valid, bus.resp_id, bus.resp_data,
               bus.resp_ovf, bus.resp_err, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    checks++;
    if ({bus.req_ready, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got rdy%b busy%b want 00/0",
               bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_add_ovf();
    int n;
    @(negedge clk);
    set_req(0, 5'd0, 32'h7FFFFFFF, 32'd1);
    bus.req_valid = 2'b01;
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL add_ready: got %b want 01", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    checks++;
    if ({bus.busy, bus.resp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL add_exec: got busy/valid %b want 10",
               {bus.busy, bus.resp_valid});
    end
    wait_resp(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL add_latency: got %0d want 2", n);
    end
    checks++;
    if ({bus.resp_id, bus.resp_err, bus.resp_ovf, bus.resp_data} !==
        {1'b0, 1'b0, 1'b1, 32'h80000000}) begin
      errors++;
      $display("FAIL add_resp: got id%b e%b o%b d%h want id0 e0 o1 d80000000",
               bus.resp_id, bus.resp_err, bus.resp_ovf, bus.resp_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL add_done: got busy/valid %b want 00",
               {bus.busy, bus.resp_valid});
    end
  endtask

  task automatic test_contention();
    int gq[$];
    logic [33:0] rq[$];
    pulse_reset();
    @(negedge clk);
    set_req(0, 5'd1, 32'd5, 32'd3);
    set_req(1, 5'd1, 32'd2, 32'd7);
    bus.req_valid = 2'b11;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      if (bus.req_ready == 2'b01) gq.push_back(0);
      if (bus.req_ready == 2'b10) gq.push_back(1);
      if (bus.resp_valid === 1'b1)
        rq.push_back({bus.resp_id, bus.resp_ovf, bus.resp_data});
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    checks++;
    if (gq.size() != 3 || rq.size() != 3) begin
      errors++;
      $display("FAIL cont_count: got %0d grants %0d resps want 3 3",
               gq.size(), rq.size());
    end else begin
      checks++;
      if (gq[0] != 0 || gq[1] != 1 || gq[2] != 0) begin
        errors++;
        $display("FAIL cont_order: got %0d %0d %0d want 0 1 0",
                 gq[0], gq[1], gq[2]);
      end
      checks++;
      if (rq[0] !== {2'b00, 32'd2}) begin
        errors++;
        $display("FAIL cont_resp0: got %h want %h", rq[0], {2'b00, 32'd2});
      end
      checks++;
      if (rq[1] !== {2'b10, 32'hFFFFFFFB}) begin
        errors++;
        $display("FAIL cont_resp1: got %h want %h",
                 rq[1], {2'b10, 32'hFFFFFFFB});
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_mulhu();
    int n;
    int bad;
    @(negedge clk);
    set_req(1, 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    bus.req_valid = 2'b10;
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL mul_ready: got %b want 10", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    n = 1;
    bad = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      if (bus.busy !== 1'b1 || bus.alu_op !== 5'd19 ||
          bus.alu_src1 !== 32'hFFFFFFFF || bus.alu_src2 !== 32'hFFFFFFFF)
        bad++;
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != MC + 1) begin
      errors++;
      $display("FAIL mul_latency: got %0d want %0d", n, MC + 1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_stable: got %0d unstable cycles want 0", bad);
    end
    checks++;
    if ({bus.resp_id, bus.resp_ovf, bus.resp_err, bus.resp_data} !==
        {3'b100, 32'hFFFFFFFE}) begin
      errors++;
      $display("FAIL mul_resp: got id%b o%b e%b d%h want id1 o0 e0 dFFFFFFFE",
               bus.resp_id, bus.resp_ovf, bus.resp_err, bus.resp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int n;
    @(negedge clk);
    set_req(0, 5'b11111, $urandom, $urandom);
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL ill_ready: got %b want 01", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    wait_resp(n);
    checks++;
    if (n != MC + 1) begin
      errors++;
      $display("FAIL ill_latency: got %0d want %0d", n, MC + 1);
    end
    checks++;
    if ({bus.resp_id, bus.resp_err, bus.resp_ovf, bus.resp_data} !==
        {3'b010, 32'h0}) begin
      errors++;
      $display("FAIL ill_resp: got id%b e%b o%b d%h want id0 e1 o0 d0",
               bus.resp_id, bus.resp_err, bus.resp_ovf, bus.resp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    logic [34:0] snap;
    logic [33:0] er;
    @(negedge clk);
    set_req(0, 5'd0, 32'd10, 32'd20);
    bus.req_valid = 2'b01;
    bus.resp_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_ready0: got %b want 01", bus.req_ready);
    end
    @(negedge clk);
    set_req(1, 5'd2, 32'h1234, 32'd3);
    bus.req_valid = 2'b10;
    #1;
    n = 1;
    bad = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      if (bus.req_ready !== 2'b00) bad++;
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 2 || bus.resp_data !== 32'd30 || bus.resp_id !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got lat %0d d%h id%b want 2 d1e id0",
               n, bus.resp_data, bus.resp_id);
    end
    snap = {bus.resp_id, bus.resp_err, bus.resp_ovf, bus.resp_data};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 2'b00 ||
          {bus.resp_id, bus.resp_err, bus.resp_ovf, bus.resp_data} !== snap)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.resp_valid, bus.req_ready} !== 3'b100) begin
      errors++;
      $display("FAIL bp_release: got v%b rdy%b want v1 rdy00",
               bus.resp_valid, bus.req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_regrant: got %b want 10", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    wait_resp(n);
    er = exp_resp(5'd2, 32'h1234, 32'd3);
    checks++;
    if (n != 2 || bus.resp_id !== 1'b1 ||
        {bus.resp_err, bus.resp_ovf, bus.resp_data} !== er) begin
      errors++;
      $display("FAIL bp_second: got lat %0d id%b %h want 2 id1 %h",
               n, bus.resp_id,
               {bus.resp_err, bus.resp_ovf, bus.resp_data}, er);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int n;
    int bad;
    @(negedge clk);
    set_req(0, 5'd16, 32'd3, 32'd4);
    bus.req_valid = 2'b01;
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rme_ready: got %b want 01", bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if ({bus.req_ready, bus.alu_op, bus.alu_src1, bus.alu_src2,
         bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_ovf,
         bus.resp_err, bus.busy} !== '0) begin
      errors++;
      $display("FAIL rme_zero: got rdy%b op%h v%b busy%b d%h want all 0",
               bus.req_ready, bus.alu_op, bus.resp_valid, bus.busy,
               bus.resp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rme_quiet: got %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    set_req(0, 5'd0, 32'd100, 32'd1);
    set_req(1, 5'd0, 32'd200, 32'd2);
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rme_first: got %b want 01", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    wait_resp(n);
    checks++;
    if (n != 2 || bus.resp_id !== 1'b0 || bus.resp_data !== 32'd101) begin
      errors++;
      $display("FAIL rme_resp: got lat %0d id%b d%h want 2 id0 d65",
               n, bus.resp_id, bus.resp_data);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_opnd();
    int s;
    s = int'($urandom % 6);
    case (s)
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    int s;
    s = int'($urandom % 4);
    case (s)
      0: return 5'($urandom % 2);
      1: return 5'd16 + 5'($urandom % 4);
      default: return 5'($urandom % 32);
    endcase
  endfunction

  // Transaction-level model: an accepted op owns the ALU until its
  // response is taken; the response shows lat(op) cycles after accept.
  task automatic test_random();
    logic [4:0]  ops [2];
    logic [31:0] as  [2];
    logic [31:0] bs  [2];
    logic [1:0]  v;
    logic [1:0]  exp_ready;
    logic        rr;
    bit          m_busy;
    int          m_wait;
    int          m_last;
    int          w;
    logic        exp_id;
    logic [33:0] exp_r;
    logic        vis;
    pulse_reset();
    m_busy = 0;
    m_wait = 0;
    m_last = 1;
    exp_id = 1'b0;
    exp_r = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ops[i] = rand_op();
        as[i] = rand_opnd();
        bs[i] = rand_opnd();
        set_req(i, ops[i], as[i], bs[i]);
      end
      v = 2'($urandom % 4);
      rr = ($urandom % 4) != 0;
      bus.req_valid = v;
      bus.resp_ready = rr;
      #1;
      exp_ready = 2'b00;
      if (!m_busy) begin
        if (v == 2'b11) exp_ready = (m_last == 1) ? 2'b01 : 2'b10;
        else            exp_ready = v;
      end
      vis = m_busy && m_wait == 0;
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++;
        $display("FAIL rnd_ready cyc %0d: got %b want %b",
                 cyc, bus.req_ready, exp_ready);
      end
      checks++;
      if (bus.busy !== m_busy || bus.resp_valid !== vis) begin
        errors++;
        $display("FAIL rnd_state cyc %0d: got busy%b v%b want busy%b v%b",
                 cyc, bus.busy, bus.resp_valid, m_busy, vis);
      end
      if (vis) begin
        checks++;
        if (bus.resp_id !== exp_id ||
            {bus.resp_err, bus.resp_ovf, bus.resp_data} !== exp_r) begin
          errors++;
          $display("FAIL rnd_resp cyc %0d: got id%b %h want id%b %h",
                   cyc, bus.resp_id,
                   {bus.resp_err, bus.resp_ovf, bus.resp_data},
                   exp_id, exp_r);
        end
      end
      if (exp_ready != 2'b00) begin
        w = exp_ready[1] ? 1 : 0;
        m_busy = 1;
        m_wait = lat(ops[w]) - 1;
        m_last = w;
        exp_id = exp_ready[1];
        exp_r = exp_resp(ops[w], as[w], bs[w]);
      end else if (m_busy) begin
        if (m_wait > 0) m_wait--;
        else if (rr) m_busy = 0;
      end
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.resp_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.resp_ready = 1'b0;
    bus.req_op = '0;
    bus.req_src1 = '0;
    bus.req_src2 = '0;
    test_reset();
    test_add_ovf();
    test_contention();
    test_mulhu();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences a single shared combinational ALU between two requesters (e.g. integer pipe and address/branch unit).
- Round-robin arbitration, operand latching, fixed multi-cycle execution window for multiply ops, and a held response with valid/ready handshake.
- Sits between requesters and the ALU instance; drives the ALU's alu_op/src1/src2 inputs and samples its alu_out/alu_overflow.

Parameters:
- DATA_SIZE, 32, operand/result width.
- OP_SIZE, 5, ALU opcode width.
- MUL_CYCLES, 2, execute cycles for ops with op[4]=1 (MUL, MULH, MULHSU, MULHU); must be >=1.
- MAX_OP, 5'b10011, highest legal opcode (MULHU).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit set.
- req_op  in  2*OP_SIZE  opcodes; requester i uses [i*OP_SIZE +: OP_SIZE].
- req_src1  in  2*DATA_SIZE  first operands, packed the same way.
- req_src2  in  2*DATA_SIZE  second operands, packed the same way.
- alu_op  out  OP_SIZE  to ALU; registered.
- alu_src1  out  DATA_SIZE  to ALU; registered.
- alu_src2  out  DATA_SIZE  to ALU; registered.
- alu_result  in  DATA_SIZE  from ALU alu_out.
- alu_ovf  in  1  from ALU alu_overflow.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accept.
- resp_id  out  1  requester index owning the response.
- resp_data  out  DATA_SIZE  captured result.
- resp_ovf  out  1  captured overflow (ADD/SUB only).
- resp_err  out  1  illegal opcode flag.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset (async, rst=1): state=IDLE; last_grant=1 (so requester 0 wins first contention); cnt=0.
  - All outputs 0: req_ready, alu_op/src1/src2, resp_valid, resp_id, resp_data, resp_ovf, resp_err, busy.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational from req_valid and last_grant.
  - Exactly one valid -> that requester's ready=1.
  - Both valid -> ready to requester != last_grant.
  - None valid -> req_ready=0.
  - On handshake (valid&ready):
    - latch op/src1/src2 into alu_* regs; resp_id<=winner; last_grant<=winner.
    - cnt<=(op[4] ? MUL_CYCLES : 1)-1; go EXEC.
- EXEC:
  - req_ready=0; alu_* held constant.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0:
    - resp_data<=alu_result.
    - resp_ovf<=alu_ovf if op is ADD(00000) or SUB(00001), else 0.
    - resp_err<=(op>MAX_OP); when resp_err=1, resp_data<=0 regardless of alu_result.
    - resp_valid<=1; go RESP.
- RESP:
  - resp_* held stable while resp_valid=1 and resp_ready=0.
  - resp_valid&resp_ready: resp_valid<=0, go IDLE.
  - No new grant in the same cycle; earliest next handshake is the following IDLE cycle.
- Latency, handshake to resp_valid:
  - 2 cycles for single-cycle ops: EXEC 1 cycle, resp_valid visible the next cycle.
  - MUL_CYCLES+1 cycles for op[4]=1.
- Throughput: at most 1 op per 3 cycles (non-MUL) with resp_ready tied high.
- alu_* outputs keep their last values after completion; no clearing required.
- A requester dropping req_valid while not granted is legal; nothing is latched for it.
- Fairness: under continuous contention, grants alternate 0,1,0,1...
- resp_ready during IDLE/EXEC is ignored.
- rst asserted mid-EXEC or mid-RESP: immediate return to reset values; the in-flight op is dropped with no response.
- busy = (state!=IDLE).

Test Plan:
- Req0 only, op=ADD, src1=32'h7FFFFFFF, src2=1 -> req_ready=2'b01 in handshake cycle; 2 cycles later resp_valid=1, resp_id=0, resp_data=32'h80000000, resp_ovf=1, resp_err=0.
- Both valid from reset, op=SUB, (5,3) on req0 and (2,7) on req1:
  - grant order is req0 then req1.
  - responses: id0 data=2 ovf=0; id1 data=32'hFFFFFFFB ovf=0.
  - both held continuously valid -> next grant goes to req0 again.
- Req1, op=MULHU, src1=src2=32'hFFFFFFFF, MUL_CYCLES=2 -> busy 3 cycles before resp_valid; resp_data=32'hFFFFFFFE; alu_* stable throughout EXEC.
- Req0, op=5'b11111 -> resp_err=1, resp_data=0, resp_ovf=0.
- Backpressure: resp_ready=0 for 5 cycles while req1 valid:
  - resp_* unchanged and req_ready=0 throughout.
  - req1 granted on the first IDLE cycle after resp_ready=1.
- Assert rst one cycle into a MUL EXEC -> all outputs 0 immediately, no resp_valid afterward; first post-reset contention grants req0.
